// File: rtl/serial_controller_interface_m_if.sv
// Handshake and pad-side signals of the serial game-pad poller.
// The slave modport is the poller; the master modport is the host/pad side.
interface serial_controller_interface_m_if #(
    parameter int NUM_CONTROLLERS     = 2,
    parameter int BITS_PER_CONTROLLER = 8
);
    localparam int W = NUM_CONTROLLERS * BITS_PER_CONTROLLER;

    logic                       start_fetch;
    logic                       busy;
    logic                       done;
    logic                       controller_latch;
    logic                       controller_clk;
    logic [NUM_CONTROLLERS-1:0] controller_data_B_LIST;
    logic [W-1:0]               controller_data_out_LIST;
    logic [W-1:0]               controller_pressed_LIST;
    logic [W-1:0]               controller_released_LIST;

    modport master (
        output start_fetch, controller_data_B_LIST,
        input  busy, done, controller_latch, controller_clk,
        input  controller_data_out_LIST, controller_pressed_LIST, controller_released_LIST
    );

    modport slave (
        input  start_fetch, controller_data_B_LIST,
        output busy, done, controller_latch, controller_clk,
        output controller_data_out_LIST, controller_pressed_LIST, controller_released_LIST
    );
endinterface

// File: rtl/serial_controller_interface_m.sv
// Polls NUM_CONTROLLERS NES/SNES-style serial pads in lockstep: latch, shift, publish with edge flags.
// state | meaning:  IDLE wait for start_fetch | LATCH pads load | SHIFT clock bits in | DONE publish lists
module serial_controller_interface_m #(
    parameter int NUM_CONTROLLERS     = 2,
    parameter int BITS_PER_CONTROLLER = 8,
    parameter int CLK_DIV             = 2
) (
    input logic clk,
    input logic rst,
    serial_controller_interface_m_if.slave bus
);
    localparam int         W         = NUM_CONTROLLERS * BITS_PER_CONTROLLER;
    localparam logic [8:0] PERIOD_M1 = 9'(2 * CLK_DIV - 1);
    localparam logic [8:0] HALF      = 9'(CLK_DIV);
    localparam logic [4:0] LAST_BIT  = 5'(BITS_PER_CONTROLLER - 1);

    typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_e;

    state_e                         state_q, state_d;
    logic [8:0]                     cnt_q, cnt_d;
    logic [4:0]                     bit_q, bit_d;
    logic [NUM_CONTROLLERS-1:0]     sync1_q, sync2_q;
    logic [W-1:0]                   shift_q, shift_d;
    logic [W-1:0]                   data_q, data_d;
    logic [W-1:0]                   pressed_q, pressed_d;
    logic [W-1:0]                   released_q, released_d;
    logic                           ctl_clk_q, ctl_clk_d;
    logic [BITS_PER_CONTROLLER-1:0] pad;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        data_d     = data_q;
        pressed_d  = pressed_q;
        released_d = released_q;
        pad        = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.start_fetch) begin
                    state_d = LATCH;
                    cnt_d   = PERIOD_M1;
                end
            end
            LATCH: begin
                if (cnt_q == 9'd0) begin
                    state_d = SHIFT;
                    cnt_d   = PERIOD_M1;
                    bit_d   = LAST_BIT;
                end else begin
                    cnt_d = cnt_q - 9'd1;
                end
            end
            SHIFT: begin
                // cnt_q == HALF is the last cycle of the low phase
                if (cnt_q == HALF) begin
                    for (int n = 0; n < NUM_CONTROLLERS; n++) begin
                        pad    = shift_q[n*BITS_PER_CONTROLLER +: BITS_PER_CONTROLLER];
                        pad    = pad << 1;
                        pad[0] = ~sync2_q[n];
                        shift_d[n*BITS_PER_CONTROLLER +: BITS_PER_CONTROLLER] = pad;
                    end
                end
                if (cnt_q == 9'd0) begin
                    if (bit_q == 5'd0) begin
                        // Lists are loaded on entry so they are already valid during DONE
                        state_d    = DONE;
                        data_d     = shift_q;
                        pressed_d  = shift_q & ~data_q;
                        released_d = ~shift_q & data_q;
                    end else begin
                        bit_d = bit_q - 5'd1;
                        cnt_d = PERIOD_M1;
                    end
                end else begin
                    cnt_d = cnt_q - 9'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ctl_clk_d = !((state_d == SHIFT) && (cnt_d >= HALF));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            pressed_q  <= '0;
            released_q <= '0;
            ctl_clk_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sync1_q    <= bus.controller_data_B_LIST;
            sync2_q    <= sync1_q;
            shift_q    <= shift_d;
            data_q     <= data_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            ctl_clk_q  <= ctl_clk_d;
        end
    end

    assign bus.busy                     = (state_q == LATCH) || (state_q == SHIFT);
    assign bus.done                     = (state_q == DONE);
    assign bus.controller_latch         = (state_q == LATCH);
    assign bus.controller_clk           = ctl_clk_q;
    assign bus.controller_data_out_LIST = data_q;
    assign bus.controller_pressed_LIST  = pressed_q;
    assign bus.controller_released_LIST = released_q;
endmodule

// File: tb/tb_serial_controller_interface_m.sv
// Scoreboard bench: two poller instances (defaults, and 3 pads x 12 bits with CLK_DIV=3) driven by pad models.
module tb_serial_controller_interface_m;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int compared   = 0;
    int mismatched = 0;

    serial_controller_interface_m_if #(.NUM_CONTROLLERS(2), .BITS_PER_CONTROLLER(8))  ifa ();
    serial_controller_interface_m_if #(.NUM_CONTROLLERS(3), .BITS_PER_CONTROLLER(12)) ifb ();

    serial_controller_interface_m #(.NUM_CONTROLLERS(2), .BITS_PER_CONTROLLER(8), .CLK_DIV(2))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    serial_controller_interface_m #(.NUM_CONTROLLERS(3), .BITS_PER_CONTROLLER(12), .CLK_DIV(3))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    typedef struct {
        logic [63:0] data;
        logic [63:0] pr;
        logic [63:0] rl;
        int          cyc;
    } exp_t;

    exp_t sbA[$];
    exp_t sbB[$];
    exp_t eA, eB;
    int   doneA = 0, doneB = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pad models: latch reloads, every controller_clk rising edge advances one bit, MSB first, active-low.
    logic [7:0]  btnA [2];
    logic [11:0] btnB [3];
    int   idxA = 8, idxB = 12;
    logic pclkA = 1'b1, pclkB = 1'b1;

    always @(negedge clk) begin
        if (ifa.controller_latch) idxA = 0;
        else if (ifa.controller_clk && !pclkA) idxA++;
        pclkA = ifa.controller_clk;
        for (int n = 0; n < 2; n++)
            ifa.controller_data_B_LIST[n] = (idxA < 8) ? ~btnA[n][7-idxA] : 1'b1;
        if (ifb.controller_latch) idxB = 0;
        else if (ifb.controller_clk && !pclkB) idxB++;
        pclkB = ifb.controller_clk;
        for (int n = 0; n < 3; n++)
            ifb.controller_data_B_LIST[n] = (idxB < 12) ? ~btnB[n][11-idxB] : 1'b1;
    end

    // Waveform profile of the current scan, restarted at each latch rising edge.
    int latch_startA, latch_lenA, risesA, rise_firstA, rise_lastA, busy_lenA;
    int latch_startB, latch_lenB, risesB, rise_firstB, rise_lastB, busy_lenB;
    logic plA = 1'b0, pcA = 1'b1, plB = 1'b0, pcB = 1'b1;

    always @(negedge clk) begin
        if (ifa.controller_latch && !plA) begin
            latch_startA = cyc; latch_lenA = 0; risesA = 0; rise_firstA = 0; rise_lastA = 0; busy_lenA = 0;
        end
        if (ifa.controller_latch) latch_lenA++;
        if (ifa.busy) busy_lenA++;
        if (ifa.controller_clk && !pcA) begin
            risesA++;
            if (risesA == 1) rise_firstA = cyc;
            rise_lastA = cyc;
        end
        plA = ifa.controller_latch;
        pcA = ifa.controller_clk;
        if (ifb.controller_latch && !plB) begin
            latch_startB = cyc; latch_lenB = 0; risesB = 0; rise_firstB = 0; rise_lastB = 0; busy_lenB = 0;
        end
        if (ifb.controller_latch) latch_lenB++;
        if (ifb.busy) busy_lenB++;
        if (ifb.controller_clk && !pcB) begin
            risesB++;
            if (risesB == 1) rise_firstB = cyc;
            rise_lastB = cyc;
        end
        plB = ifb.controller_latch;
        pcB = ifb.controller_clk;
    end

    // Monitors: every done pulse must match the next expected scan.
    always @(negedge clk) begin
        if (ifa.done) begin
            doneA++;
            if (sbA.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL A_unexpected_done: got done=1 at cycle %0d, required no pulse", cyc);
            end else begin
                eA = sbA.pop_front();
                check("A_done_cycle", 64'(cyc), 64'(eA.cyc));
                check("A_busy_at_done", 64'(ifa.busy), 64'd0);
                check("A_data_out", 64'(ifa.controller_data_out_LIST), eA.data);
                check("A_pressed", 64'(ifa.controller_pressed_LIST), eA.pr);
                check("A_released", 64'(ifa.controller_released_LIST), eA.rl);
            end
        end
        if (ifb.done) begin
            doneB++;
            if (sbB.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL B_unexpected_done: got done=1 at cycle %0d, required no pulse", cyc);
            end else begin
                eB = sbB.pop_front();
                check("B_done_cycle", 64'(cyc), 64'(eB.cyc));
                check("B_busy_at_done", 64'(ifb.busy), 64'd0);
                check("B_data_out", 64'(ifb.controller_data_out_LIST), eB.data);
                check("B_pressed", 64'(ifb.controller_pressed_LIST), eB.pr);
                check("B_released", 64'(ifb.controller_released_LIST), eB.rl);
            end
        end
    end

    task automatic wait_sb(input bit which_b, input int maxc);
        int n = 0;
        while (((which_b ? sbB.size() : sbA.size()) != 0) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        #1;
        if ((which_b ? sbB.size() : sbA.size()) != 0) begin
            compared++; mismatched++;
            $display("FAIL %s_done_timeout: got no done within %0d cycles, required one", which_b ? "B" : "A", maxc);
            if (which_b) sbB.delete(); else sbA.delete();
        end
    endtask

    logic [15:0] oldA = '0;
    logic [35:0] oldB = '0;

    task automatic scan_a(input logic [7:0] p0, input logic [7:0] p1);
        logic [15:0] nv;
        int t0;
        btnA[0] = p0; btnA[1] = p1; nv = {p1, p0};
        @(negedge clk);
        t0 = cyc;
        sbA.push_back('{64'(nv), 64'(nv & ~oldA), 64'(~nv & oldA), t0 + 37});
        oldA = nv;
        ifa.start_fetch = 1'b1;
        @(negedge clk);
        ifa.start_fetch = 1'b0;
        wait_sb(1'b0, 100);
        check("A_latch_start", 64'(latch_startA), 64'(t0 + 1));
        check("A_latch_len", 64'(latch_lenA), 64'd4);
        check("A_clk_rises", 64'(risesA), 64'd8);
        check("A_first_rise", 64'(rise_firstA), 64'(t0 + 7));
        check("A_last_rise", 64'(rise_lastA), 64'(t0 + 35));
        check("A_busy_len", 64'(busy_lenA), 64'd36);
    endtask

    task automatic scan_b(input logic [11:0] p0, input logic [11:0] p1, input logic [11:0] p2);
        logic [35:0] nv;
        int t0;
        btnB[0] = p0; btnB[1] = p1; btnB[2] = p2; nv = {p2, p1, p0};
        @(negedge clk);
        t0 = cyc;
        sbB.push_back('{64'(nv), 64'(nv & ~oldB), 64'(~nv & oldB), t0 + 79});
        oldB = nv;
        ifb.start_fetch = 1'b1;
        @(negedge clk);
        ifb.start_fetch = 1'b0;
        wait_sb(1'b1, 150);
        check("B_latch_start", 64'(latch_startB), 64'(t0 + 1));
        check("B_latch_len", 64'(latch_lenB), 64'd6);
        check("B_clk_rises", 64'(risesB), 64'd12);
        check("B_first_rise", 64'(rise_firstB), 64'(t0 + 10));
        check("B_last_rise", 64'(rise_lastB), 64'(t0 + 76));
        check("B_busy_len", 64'(busy_lenB), 64'd78);
    endtask

    initial begin
        int t0, d0;
        ifa.start_fetch = 1'b0;
        ifb.start_fetch = 1'b0;
        btnA[0] = '0; btnA[1] = '0;
        btnB[0] = '0; btnB[1] = '0; btnB[2] = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(ifa.busy), 64'd0);
        check("rst_done", 64'(ifa.done), 64'd0);
        check("rst_latch", 64'(ifa.controller_latch), 64'd0);
        check("rst_ctl_clk", 64'(ifa.controller_clk), 64'd1);
        check("rst_data_A", 64'(ifa.controller_data_out_LIST), 64'd0);
        check("rst_data_B", 64'(ifb.controller_data_out_LIST), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        scan_a(8'hA5, 8'h3C);
        scan_a(8'h0F, 8'h3C);

        // Re-pulses during the scan and in DONE are dropped; a pulse right after DONE starts anew.
        @(negedge clk);
        t0 = cyc; d0 = doneA;
        sbA.push_back('{64'(oldA), 64'd0, 64'd0, t0 + 37});
        sbA.push_back('{64'(oldA), 64'd0, 64'd0, t0 + 38 + 37});
        for (int k = 0; k <= 38; k++) begin
            ifa.start_fetch = (k == 0 || k == 10 || k == 37 || k == 38);
            if (k == 38) check("A_idle_after_done_latch", 64'(ifa.controller_latch), 64'd0);
            @(negedge clk);
        end
        ifa.start_fetch = 1'b0;
        check("A_restart_latch_c39", 64'(ifa.controller_latch), 64'd1);
        check("A_one_done_by_c39", 64'(doneA - d0), 64'd1);
        wait_sb(1'b0, 100);
        check("A_done_count_repulse", 64'(doneA - d0), 64'd2);

        // Reset in the middle of a scan aborts it; reset also beats a simultaneous start.
        btnA[0] = 8'h55; btnA[1] = 8'hAA;
        @(negedge clk);
        d0 = doneA;
        for (int k = 0; k <= 21; k++) begin
            ifa.start_fetch = (k == 0 || k == 21);
            rst = (k >= 20);
            if (k == 21) begin
                check("A_abort_latch", 64'(ifa.controller_latch), 64'd0);
                check("A_abort_ctl_clk", 64'(ifa.controller_clk), 64'd1);
                check("A_abort_busy", 64'(ifa.busy), 64'd0);
                check("A_abort_data", 64'(ifa.controller_data_out_LIST), 64'd0);
                check("A_abort_pressed", 64'(ifa.controller_pressed_LIST), 64'd0);
                check("A_abort_released", 64'(ifa.controller_released_LIST), 64'd0);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        ifa.start_fetch = 1'b0;
        check("A_rst_beats_start_busy", 64'(ifa.busy), 64'd0);
        check("A_rst_beats_start_latch", 64'(ifa.controller_latch), 64'd0);
        repeat (60) @(negedge clk);
        check("A_no_done_after_abort", 64'(doneA - d0), 64'd0);
        oldA = '0;
        oldB = '0;
        scan_a(8'h0F, 8'h3C);

        scan_b(12'hABC, 12'h123, 12'hF0F);
        scan_b(12'hA0C, 12'h123, 12'hFFF);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
